// File: rtl/scoreboard_register_file_pkg.sv
// Shared definitions for the scoreboarded decode register file.
package scoreboard_register_file_pkg;

  localparam int RF_XLEN_DEF         = 32;
  localparam int RF_NUM_REGS_DEF     = 32;
  localparam int RF_MAX_INFLIGHT_DEF = 3;

  localparam int RF_ADDR_W = $clog2(RF_NUM_REGS_DEF);
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  // Width of a per-register in-flight counter able to hold 0..max_inflight.
  function automatic int sb_cnt_w(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/scoreboard_register_file_sb_counter.sv
// One per-register in-flight write counter: saturating up/down with clear.
module sb_counter #(
  parameter int MAX = 3,
  parameter int CW  = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] r_count;

  // Clear wins; inc+dec together cancel; never wraps in either direction.
  always_ff @(posedge CLK) begin
    if (RST || clr)
      r_count <= '0;
    else if (inc && !dec && r_count != MAX_C)
      r_count <= r_count + 1'b1;
    else if (dec && !inc && r_count != '0)
      r_count <= r_count - 1'b1;
  end

  assign count = r_count;
  assign full  = (r_count == MAX_C);

endmodule

// File: rtl/scoreboard_register_file.sv
// Decode-stage register file with N combinational read ports, write-through
// bypass, hardwired x0 and a per-register in-flight write scoreboard that
// stalls issue on RAW (source pending) and WAW (destination counter full).
module scoreboard_register_file
  import scoreboard_register_file_pkg::*;
#(
  parameter int XLEN         = RF_XLEN_DEF,
  parameter int NUM_REGS     = RF_NUM_REGS_DEF,
  parameter int NUM_RD_PORTS = 2,
  parameter int MAX_INFLIGHT = RF_MAX_INFLIGHT_DEF,
  parameter int BYPASS_EN    = 1,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0]     REG_R_Addr,
  output logic [NUM_RD_PORTS-1:0][XLEN-1:0]   REG_R_Data,
  output logic [NUM_RD_PORTS-1:0]             REG_R_Busy,
  input  logic                                REG_W_En,
  input  logic [AW-1:0]                       REG_W_Addr,
  input  logic [XLEN-1:0]                     REG_W_Data,
  input  logic                                ISSUE_Valid,
  input  logic                                ISSUE_Rd_En,
  input  logic [AW-1:0]                       ISSUE_Rd,
  input  logic [NUM_RD_PORTS-1:0]             ISSUE_Rs_Used,
  output logic                                ISSUE_Stall,
  input  logic                                FLUSH
);

  localparam int CW = sb_cnt_w(MAX_INFLIGHT);
  localparam logic BYP = (BYPASS_EN != 0);

  logic [NUM_REGS-1:0][XLEN-1:0] r_regs;
  logic [NUM_REGS-1:0][CW-1:0]   w_cnt;
  logic [NUM_REGS-1:0]           w_full;
  logic                          w_wr_hit;
  logic                          w_rs_hazard;
  logic                          w_waw;
  logic                          w_accept;

  // A write to x0 is a no-op for both data and scoreboard.
  assign w_wr_hit = REG_W_En && (REG_W_Addr != '0);

  // Register array; x0 is reset to zero and never written.
  always_ff @(posedge CLK) begin
    if (RST)
      r_regs <= '0;
    else if (w_wr_hit)
      r_regs[REG_W_Addr] <= REG_W_Data;
  end

  // Read muxes with optional write-through and source-pending flag.
  always_comb begin
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      REG_R_Data[i] = r_regs[REG_R_Addr[i]];
      REG_R_Busy[i] = 1'b0;
      if (REG_R_Addr[i] == '0)
        REG_R_Data[i] = '0;
      else if (BYP && w_wr_hit && REG_W_Addr == REG_R_Addr[i])
        REG_R_Data[i] = REG_W_Data;
      // Last outstanding producer writing back now releases the consumer
      // only when forwarding can deliver the value in this same cycle.
      if (w_cnt[REG_R_Addr[i]] != '0)
        REG_R_Busy[i] = !(w_cnt[REG_R_Addr[i]] == CW'(1) && BYP && w_wr_hit &&
                          REG_W_Addr == REG_R_Addr[i]);
    end
  end

  assign w_rs_hazard = |(ISSUE_Rs_Used & REG_R_Busy);
  // A full destination is still accepted if a writeback frees a slot now.
  assign w_waw       = ISSUE_Rd_En && (ISSUE_Rd != '0) && w_full[ISSUE_Rd] &&
                       !(REG_W_En && REG_W_Addr == ISSUE_Rd);
  assign ISSUE_Stall = ISSUE_Valid && (w_rs_hazard || w_waw);
  assign w_accept    = ISSUE_Valid && !ISSUE_Stall && !FLUSH;

  assign w_cnt[0]  = '0;
  assign w_full[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    logic w_inc, w_dec;
    assign w_inc = w_accept && ISSUE_Rd_En && (ISSUE_Rd == AW'(r));
    assign w_dec = REG_W_En && (REG_W_Addr == AW'(r)) && (w_cnt[r] != '0);
    sb_counter #(.MAX(MAX_INFLIGHT), .CW(CW)) u_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (w_inc),
      .dec   (w_dec),
      .clr   (FLUSH),
      .count (w_cnt[r]),
      .full  (w_full[r])
    );
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench: stimulus pushes expected read data / busy / stall values
// tagged with the cycle they apply to; a monitor compares on the falling edge.
module tb_scoreboard_register_file;
  import scoreboard_register_file_pkg::*;

  localparam int NP = 2;
  localparam int XL = 32;

  logic                          CLK = 1'b0;
  logic                          RST;
  logic [NP-1:0][RF_ADDR_W-1:0]  REG_R_Addr;
  logic [NP-1:0][XL-1:0]         REG_R_Data;
  logic [NP-1:0]                 REG_R_Busy;
  logic                          REG_W_En;
  rf_addr_t                      REG_W_Addr;
  logic [XL-1:0]                 REG_W_Data;
  logic                          ISSUE_Valid;
  logic                          ISSUE_Rd_En;
  rf_addr_t                      ISSUE_Rd;
  logic [NP-1:0]                 ISSUE_Rs_Used;
  logic                          ISSUE_Stall;
  logic                          FLUSH;

  scoreboard_register_file #(
    .XLEN(XL), .NUM_REGS(32), .NUM_RD_PORTS(NP), .MAX_INFLIGHT(3), .BYPASS_EN(1)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REG_R_Addr(REG_R_Addr), .REG_R_Data(REG_R_Data), .REG_R_Busy(REG_R_Busy),
    .REG_W_En(REG_W_En), .REG_W_Addr(REG_W_Addr), .REG_W_Data(REG_W_Data),
    .ISSUE_Valid(ISSUE_Valid), .ISSUE_Rd_En(ISSUE_Rd_En), .ISSUE_Rd(ISSUE_Rd),
    .ISSUE_Rs_Used(ISSUE_Rs_Used), .ISSUE_Stall(ISSUE_Stall), .FLUSH(FLUSH)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    int          kind;   // 0 data, 1 busy, 2 stall
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge CLK) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        0:       act = REG_R_Data[e.port];
        1:       act = {31'b0, REG_R_Busy[e.port]};
        default: act = {31'b0, ISSUE_Stall};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s (cycle %0d port %0d): got %h expected %h",
                 e.name, cyc, e.port, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    REG_R_Addr    = '0;
    REG_W_En      = 1'b0;
    REG_W_Addr    = '0;
    REG_W_Data    = '0;
    ISSUE_Valid   = 1'b0;
    ISSUE_Rd_En   = 1'b0;
    ISSUE_Rd      = '0;
    ISSUE_Rs_Used = '0;
    FLUSH         = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    REG_W_En   = 1'b1;
    REG_W_Addr = RF_ADDR_W'(a);
    REG_W_Data = d;
  endtask

  task automatic issue_rd(input int rd);
    ISSUE_Valid = 1'b1;
    ISSUE_Rd_En = 1'b1;
    ISSUE_Rd    = RF_ADDR_W'(rd);
  endtask

  task automatic exd(input int p, input logic [31:0] v, input string n);
    q.push_back('{cyc, 0, p, v, n});
  endtask
  task automatic exb(input int p, input logic b, input string n);
    q.push_back('{cyc, 1, p, {31'b0, b}, n});
  endtask
  task automatic exs(input logic b, input string n);
    q.push_back('{cyc, 2, 0, {31'b0, b}, n});
  endtask

  initial begin
    RST = 1'b1;
    idle();
    step();
    step();
    RST = 1'b0;

    // Reset state: every address reads zero and nothing is pending.
    for (int a = 0; a < 32; a += 2) begin
      idle();
      REG_R_Addr[0] = RF_ADDR_W'(a);
      REG_R_Addr[1] = RF_ADDR_W'(a + 1);
      exd(0, 32'h0, "reset_data_p0");
      exd(1, 32'h0, "reset_data_p1");
      exb(0, 1'b0, "reset_busy_p0");
      exb(1, 1'b0, "reset_busy_p1");
      exs(1'b0, "reset_stall");
      step();
    end

    // x5 write, forwarded the same cycle and stored afterwards.
    idle(); wr(5, 32'hDEADBEEF); REG_R_Addr[0] = 5;
    exd(0, 32'hDEADBEEF, "bypass_x5"); step();
    idle(); REG_R_Addr[0] = 5;
    exd(0, 32'hDEADBEEF, "read_x5"); step();

    // x0 write ignored.
    idle(); wr(0, 32'h1234); REG_R_Addr[0] = 0; REG_R_Addr[1] = 5;
    exd(0, 32'h0, "x0_wr_same_cycle"); exd(1, 32'hDEADBEEF, "x5_hold"); step();
    idle(); REG_R_Addr[0] = 0;
    exd(0, 32'h0, "x0_after_wr"); step();

    // x7 forwarded to port 1 during writeback.
    idle(); wr(7, 32'h11111111); step();
    idle(); wr(7, 32'hA5A5A5A5); REG_R_Addr[0] = 7; REG_R_Addr[1] = 7;
    exd(1, 32'hA5A5A5A5, "bypass_x7_p1"); exd(0, 32'hA5A5A5A5, "bypass_x7_p0"); step();
    idle(); REG_R_Addr[1] = 7;
    exd(1, 32'hA5A5A5A5, "read_x7"); step();

    // RAW: producer of x3 then a consumer of x3.
    idle(); issue_rd(3);
    exs(1'b0, "issue_rd3"); step();
    for (int k = 0; k < 2; k++) begin
      idle(); ISSUE_Valid = 1'b1; ISSUE_Rs_Used = 2'b01; REG_R_Addr[0] = 3;
      exb(0, 1'b1, "busy_x3"); exs(1'b1, "raw_stall"); step();
    end
    idle(); ISSUE_Valid = 1'b1; ISSUE_Rs_Used = 2'b01; REG_R_Addr[0] = 3;
    wr(3, 32'h33333333);
    exs(1'b0, "raw_release"); exb(0, 1'b0, "raw_busy_release");
    exd(0, 32'h33333333, "raw_bypass_data"); step();
    idle(); REG_R_Addr[0] = 3;
    exb(0, 1'b0, "x3_drained"); exd(0, 32'h33333333, "x3_stored"); step();

    // WAW: fill x9 to MAX_INFLIGHT.
    for (int k = 0; k < 3; k++) begin
      idle(); issue_rd(9);
      exs(1'b0, "waw_fill_accept"); step();
    end
    idle(); issue_rd(9);
    exs(1'b1, "waw_full_stall"); step();
    idle(); issue_rd(9); wr(9, 32'h99); REG_R_Addr[0] = 9;
    exs(1'b0, "waw_wb_accept"); exb(0, 1'b1, "x9_busy_cnt3"); step();
    idle(); issue_rd(9);
    exs(1'b1, "waw_cnt_held"); step();
    for (int k = 0; k < 3; k++) begin
      idle(); wr(9, 32'h90 + k); REG_R_Addr[0] = 9;
      exb(0, (k == 2) ? 1'b0 : 1'b1, "x9_drain_busy"); step();
    end
    idle(); REG_R_Addr[0] = 9;
    exb(0, 1'b0, "x9_idle_busy"); exd(0, 32'h92, "x9_last_data"); step();

    // FLUSH squashes x4/x6 producers and a simultaneous accept of x8.
    idle(); issue_rd(4); exs(1'b0, "issue_rd4"); step();
    idle(); issue_rd(6); REG_R_Addr[0] = 4;
    exb(0, 1'b1, "x4_busy_pre_flush"); exs(1'b0, "issue_rd6"); step();
    idle(); FLUSH = 1'b1; issue_rd(8);
    exs(1'b0, "flush_cycle_issue"); step();
    idle(); ISSUE_Valid = 1'b1; ISSUE_Rs_Used = 2'b01; REG_R_Addr[0] = 4; REG_R_Addr[1] = 6;
    exs(1'b0, "post_flush_rs4"); exb(1, 1'b0, "x6_cleared"); step();
    idle(); wr(4, 32'h44444444); REG_R_Addr[0] = 4; REG_R_Addr[1] = 8;
    exd(0, 32'h44444444, "late_wb_bypass"); exb(0, 1'b0, "late_wb_busy");
    exb(1, 1'b0, "x8_not_counted"); step();
    idle(); ISSUE_Valid = 1'b1; ISSUE_Rs_Used = 2'b01; REG_R_Addr[0] = 4;
    exs(1'b0, "late_wb_no_underflow"); exd(0, 32'h44444444, "late_wb_stored"); step();

    // RST in the middle of in-flight traffic.
    idle(); issue_rd(4); step();
    idle(); issue_rd(6); step();
    idle(); RST = 1'b1; issue_rd(5); wr(4, 32'h55); step();
    RST = 1'b0;
    idle(); REG_R_Addr[0] = 4; REG_R_Addr[1] = 5;
    exd(0, 32'h0, "rst_x4_data"); exd(1, 32'h0, "rst_x5_data");
    exb(0, 1'b0, "rst_x4_busy"); exb(1, 1'b0, "rst_x5_busy"); step();
    idle(); REG_R_Addr[0] = 6; REG_R_Addr[1] = 7;
    exb(0, 1'b0, "rst_x6_busy"); exd(1, 32'h0, "rst_x7_data"); step();

    step();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_register_file.md
# scoreboard_register_file

Parametrised successor to the decode-stage register file. It adds N combinational read ports with write-through bypass and x0 hardwiring, plus a per-register in-flight write scoreboard that raises a decode stall on RAW/WAW hazards. It sits in decode: read ports feed operand fetch, the issue port is driven by decode when an instruction leaves for execute, and the write port is driven by writeback.

## Interface
Parameters:
- XLEN, 32, register data width.
- NUM_REGS, 32, register count; a power of two and at least 2. Index 0 is hardwired zero.
- NUM_RD_PORTS, 2, number of read ports, from 1 to 4.
- MAX_INFLIGHT, 3, maximum outstanding writes tracked per register. Counter width is $clog2(MAX_INFLIGHT+1).
- BYPASS_EN, 1, 1 enables write-through forwarding on read ports.

Ports (AW = $clog2(NUM_REGS)):
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- REG_R_Addr  in  [NUM_RD_PORTS][AW]  read addresses.
- REG_R_Data  out  [NUM_RD_PORTS][XLEN]  read data.
- REG_R_Busy  out  [NUM_RD_PORTS]  addressed register has a pending write not satisfied this cycle.
- REG_W_En  in  1  writeback valid.
- REG_W_Addr  in  AW  writeback destination.
- REG_W_Data  in  XLEN  writeback data.
- ISSUE_Valid  in  1  decode wants to issue.
- ISSUE_Rd_En  in  1  issuing instruction writes rd.
- ISSUE_Rd  in  AW  destination.
- ISSUE_Rs_Used  in  [NUM_RD_PORTS]  which read ports carry real sources.
- ISSUE_Stall  out  1  issue blocked this cycle.
- FLUSH  in  1  squash all in-flight producers.

## Operation
- Storage holds NUM_REGS×XLEN registers and a cnt[r] counter per register. On RST, all registers and counters clear to 0.
- Write: on a rising edge with REG_W_En=1 and REG_W_Addr≠0, the register is updated. Writes to x0 are ignored, and x0 is never counted.
- Read port i is combinational:
  - Address 0 returns 0.
  - If BYPASS_EN and REG_W_En and REG_W_Addr==REG_R_Addr[i]≠0, it returns REG_W_Data.
  - Otherwise it returns the stored value.
- Satisfied condition, per port i: true when cnt[a]==0, or when cnt[a]==1 and (BYPASS_EN and REG_W_En and REG_W_Addr==a). REG_R_Busy[i] = !satisfied.
- ISSUE_Stall = ISSUE_Valid && (any i with ISSUE_Rs_Used[i] && REG_R_Busy[i], or ISSUE_Rd_En && ISSUE_Rd≠0 && cnt[ISSUE_Rd]==MAX_INFLIGHT && the register is not being written this cycle).
- Accept = ISSUE_Valid && !ISSUE_Stall && !FLUSH.
- Counter update per register r≠0, each edge:
  - inc = Accept && ISSUE_Rd_En && ISSUE_Rd==r.
  - dec = REG_W_En && REG_W_Addr==r && cnt[r]≠0.
  - inc only: +1. dec only: −1. Both: unchanged.
- A writeback to a register with cnt==0 is legal (for example, a producer issued before FLUSH). It updates the register and leaves the counter at 0, with no underflow.
- FLUSH: all counters go to 0 on the next edge. FLUSH overrides a simultaneous accept or writeback on the counters. The register data write still occurs.
- RST mid-operation: everything returns to reset values on that edge, and RST overrides every other input.

## Timing
- Reads, REG_R_Busy and ISSUE_Stall are zero-latency combinational outputs. There is no path from the issue inputs to REG_R_Data.
- Write-to-read latency is 0 cycles with BYPASS_EN=1, and 1 cycle otherwise.
- A scoreboard increment is visible in cnt in the cycle after Accept. A decrement is visible in the cycle after writeback, but with bypass the waiting consumer is released in the writeback cycle itself.
- Reset values: REG_R_Data is 0 for all ports, REG_R_Busy is 0, and ISSUE_Stall is 0 whenever ISSUE_Valid is 0.

## Structure
- Shared package definitions: RF_ADDR_W and an rf_addr_t typedef derived from NUM_REGS, plus default XLEN and MAX_INFLIGHT constants reused by control and hazard logic.
- Sub-module sb_counter: one saturating up/down counter with inc, dec and clr inputs, count and full outputs. It is instantiated per register 1..NUM_REGS−1 through a generate loop.
- The top level contains the register array, read muxes, bypass compare and stall reduction.

## Test plan
- Reset, then read all 32 addresses → all return 0. Write x5=0xDEADBEEF → the next cycle reads 0xDEADBEEF. Write x0=0x1234 → x0 still reads 0.
- Writeback x7=0xA5A5A5A5 while port 1 reads x7 in the same cycle → with BYPASS_EN=1 port 1 returns 0xA5A5A5A5. With BYPASS_EN=0 it returns the old value and the new value the following cycle.
- Issue with rd=x3, then issue with rs1=x3 → ISSUE_Stall=1 until the writeback cycle of x3, when ISSUE_Stall=0 and REG_R_Data carries the bypassed value.
- With MAX_INFLIGHT=3, issue rd=x9 three times, then a fourth time → the fourth issue stalls. Writeback x9 on the same cycle → Accept occurs and cnt stays at 3.
- Issue rd=x4 and rd=x6, assert FLUSH → all counters 0 on the next cycle and a rs1=x4 issue proceeds unstalled. A late writeback to x4 updates the data and cnt stays 0.
- Assert RST in the middle of the previous sequence → all registers read 0 and all REG_R_Busy are 0 on the following cycle.
